// File: rtl/region_write_arbiter_if.sv
// Bundle of producer-side and region-side write signals for region_write_arbiter.
// master: producers + region (drives requests/almostfull); slave: the arbiter.
interface region_write_arbiter_if #(
    parameter int unsigned WIDTH      = 512,
    parameter int unsigned LOG2_DEPTH = 9,
    parameter int unsigned NUM_REQ    = 3
);
    logic [NUM_REQ-1:0]                 req_we;
    logic [NUM_REQ-1:0]                 req_last;
    logic [NUM_REQ-1:0][LOG2_DEPTH-1:0] req_waddr;
    logic [NUM_REQ-1:0][WIDTH-1:0]      req_wdata;
    logic [NUM_REQ-1:0][1:0]            req_wfifobram;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0]                 grant;
    logic                               region_almostfull;
    logic                               we;
    logic [LOG2_DEPTH-1:0]              waddr;
    logic [WIDTH-1:0]                   wdata;
    logic [1:0]                         wfifobram;
    logic [NUM_REQ-1:0][31:0]           stat_beats;
    logic [31:0]                        stat_stalls;

    modport master (
        output req_we, req_last, req_waddr, req_wdata, req_wfifobram, region_almostfull,
        input  req_ready, grant, we, waddr, wdata, wfifobram, stat_beats, stat_stalls
    );

    modport slave (
        input  req_we, req_last, req_waddr, req_wdata, req_wfifobram, region_almostfull,
        output req_ready, grant, we, waddr, wdata, wfifobram, stat_beats, stat_stalls
    );
endinterface

// File: rtl/region_write_arbiter.sv
// Round-robin, burst-granular arbiter sharing one region write port among NUM_REQ producers.
// Optional statistics counters are built when REGION_ARB_STATS_EN is defined.
module region_write_arbiter #(
    parameter int unsigned WIDTH      = 512,
    parameter int unsigned LOG2_DEPTH = 9,
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    region_write_arbiter_if.slave bus_io
);
    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e                state_q, state_d;
    logic [PtrW-1:0]       owner_q, owner_d;
    logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]       beat_cnt_q, beat_cnt_d;
    logic                  accept;
    logic [PtrW-1:0]       pick, cand;
    logic                  pick_vld;

    logic                  we_q;
    logic [LOG2_DEPTH-1:0] waddr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic [1:0]            wfifobram_q;

    // Scan downwards so the requester closest to rr_ptr_q is the last one written.
    always_comb begin
        pick     = rr_ptr_q;
        cand     = rr_ptr_q;
        pick_vld = 1'b0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            cand = PtrW'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
            if (bus_io.req_we[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        accept     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!bus_io.region_almostfull && pick_vld) begin
                    owner_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = StBurst;
                end
            end
            StBurst: begin
                accept = bus_io.req_we[owner_q] && !bus_io.region_almostfull;
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (bus_io.req_last[owner_q] || (beat_cnt_q == CntW'(MAX_BURST - 1))) begin
                        state_d  = StIdle;
                        rr_ptr_d = (owner_q == PtrW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs are combinational so almostfull blocks a beat in the same cycle.
    always_comb begin
        bus_io.grant = '0;
        if (state_q == StBurst) begin
            bus_io.grant[owner_q] = 1'b1;
        end
        bus_io.req_ready = bus_io.region_almostfull ? '0 : bus_io.grant;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wfifobram_q <= '0;
        end else begin
            we_q <= accept;
            if (accept) begin
                waddr_q     <= bus_io.req_waddr[owner_q];
                wdata_q     <= bus_io.req_wdata[owner_q];
                wfifobram_q <= bus_io.req_wfifobram[owner_q];
            end
        end
    end

    assign bus_io.we        = we_q;
    assign bus_io.waddr     = waddr_q;
    assign bus_io.wdata     = wdata_q;
    assign bus_io.wfifobram = wfifobram_q;

`ifdef REGION_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] stat_beats_q;
    logic [31:0]              stat_stalls_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_beats_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (accept) begin
                stat_beats_q[owner_q] <= stat_beats_q[owner_q] + 32'd1;
            end
            if ((state_q == StBurst) && bus_io.req_we[owner_q] && bus_io.region_almostfull) begin
                stat_stalls_q <= stat_stalls_q + 32'd1;
            end
        end
    end

    assign bus_io.stat_beats  = stat_beats_q;
    assign bus_io.stat_stalls = stat_stalls_q;
`else
    assign bus_io.stat_beats  = '0;
    assign bus_io.stat_stalls = '0;
`endif
endmodule

// File: tb/tb_region_write_arbiter.sv
// Self-checking bench for region_write_arbiter: directed vector table, scripted corner cases
// and randomized producers checked against a transaction-level arbitration model.
module tb_region_write_arbiter;
    localparam int unsigned W  = 64;
    localparam int unsigned AW = 9;
    localparam int unsigned N  = 3;
    localparam int unsigned MB = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    region_write_arbiter_if #(.WIDTH(W), .LOG2_DEPTH(AW), .NUM_REQ(N)) bus ();

    region_write_arbiter #(.WIDTH(W), .LOG2_DEPTH(AW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus_io (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, fairness pointer, beats in burst, registered write.
    int              m_owner, m_rr, m_cnt;
    bit              m_we;
    logic [AW-1:0]   m_waddr;
    logic [W-1:0]    m_wdata;
    logic [1:0]      m_wfb;
    int unsigned     m_beats[N];
    int unsigned     m_stalls;

    // Producer scripts.
    int       p_left[N], p_blen[N], p_pos[N], p_n[N], p_start[N], p_pause[N];
    logic [AW-1:0] base[N];
    int       cyc, af_mode;
    logic [N-1:0] prev_grant;
    logic [N-1:0] q_grant[$];
    logic [AW-1:0] q_wr[$];

    function automatic logic [W-1:0] beat_data(input int i, input int n);
        return {16'(i), 16'(n), 32'hC0DE_0000 | 32'(n)};
    endfunction

    task automatic drive_producers(input bit af);
        bit act, pause;
        for (int i = 0; i < int'(N); i++) begin
            act   = (p_left[i] > 0) && (cyc >= p_start[i]);
            pause = (m_owner == i) && ($urandom_range(0, 99) < p_pause[i]);
            bus.req_we[i]        = act && !pause;
            bus.req_last[i]      = act && ((p_left[i] == 1) ||
                                           (p_blen[i] > 0 && p_pos[i] == p_blen[i] - 1));
            bus.req_waddr[i]     = base[i] + AW'(p_n[i]);
            bus.req_wdata[i]     = beat_data(i, p_n[i]);
            bus.req_wfifobram[i] = 2'(p_n[i] + i);
        end
        bus.region_almostfull = af;
    endtask

    task automatic check_stats();
`ifdef REGION_ARB_STATS_EN
        for (int i = 0; i < int'(N); i++) check($sformatf("stat_beats[%0d]", i),
                                                bus.stat_beats[i], 64'(m_beats[i]));
        check("stat_stalls", bus.stat_stalls, 64'(m_stalls));
`else
        for (int i = 0; i < int'(N); i++) check($sformatf("stat_beats_off[%0d]", i),
                                                bus.stat_beats[i], 64'd0);
        check("stat_stalls_off", bus.stat_stalls, 64'd0);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, bus.grant, 0);
        check({tag, "_ready"}, bus.req_ready, 0);
        check({tag, "_we"}, bus.we, 0);
        check({tag, "_waddr"}, bus.waddr, 0);
        check({tag, "_wdata"}, bus.wdata, 0);
        check({tag, "_wfifobram"}, bus.wfifobram, 0);
        for (int i = 0; i < int'(N); i++) check({tag, "_stat_beats"}, bus.stat_beats[i], 0);
        check({tag, "_stat_stalls"}, bus.stat_stalls, 0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            p_left[i] = 0; p_blen[i] = 0; p_pos[i] = 0; p_n[i] = 0; p_start[i] = 0;
            p_pause[i] = 0; m_beats[i] = 0;
        end
        m_owner = -1; m_rr = 0; m_cnt = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_wfb = '0;
        m_stalls = 0; cyc = 0; af_mode = 0; prev_grant = '0;
        drive_producers(1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        q_grant.delete();
        q_wr.delete();
    endtask

    // One clock of model-checked operation.
    task automatic step();
        logic [N-1:0] eg, er;
        bit af, acc, last;
        int o, idx;
        af = (af_mode == 1) ? (cyc >= 4 && cyc < 9) :
             (af_mode == 2) ? ($urandom_range(0, 99) < 15) : 1'b0;
        drive_producers(af);
        #1;
        eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        er = af ? '0 : eg;
        check("grant", bus.grant, eg);
        check("req_ready", bus.req_ready, er);
        check("we", bus.we, m_we);
        check("waddr", bus.waddr, m_waddr);
        check("wdata", bus.wdata, m_wdata);
        check("wfifobram", bus.wfifobram, m_wfb);
        check_stats();
        if (bus.grant != '0 && prev_grant == '0) q_grant.push_back(bus.grant);
        prev_grant = bus.grant;
        if (bus.we) q_wr.push_back(bus.waddr);

        o   = m_owner;
        acc = (o >= 0) && bus.req_we[o] && !af;
        if ((o >= 0) && bus.req_we[o] && af) m_stalls++;
        m_we = acc;
        if (acc) begin
            last    = bus.req_last[o];
            m_waddr = bus.req_waddr[o];
            m_wdata = bus.req_wdata[o];
            m_wfb   = bus.req_wfifobram[o];
            m_beats[o]++;
            m_cnt++;
            p_left[o]--;
            p_n[o]++;
            p_pos[o] = last ? 0 : p_pos[o] + 1;
            if (last || m_cnt == int'(MB)) begin
                m_rr    = (o + 1) % int'(N);
                m_owner = -1;
            end
        end else if (o < 0 && !af) begin
            for (int k = 0; k < int'(N); k++) begin
                idx = (m_rr + k) % int'(N);
                if (m_owner < 0 && bus.req_we[idx]) begin
                    m_owner = idx;
                    m_cnt   = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_done(input int cap);
        int guard = 0;
        while (((p_left[0] + p_left[1] + p_left[2]) > 0 || m_owner >= 0 || m_we) && guard < cap) begin
            step();
            guard++;
        end
        step();
        check("run_within_budget", 64'(guard < cap), 1);
    endtask

    typedef struct {
        logic [N-1:0]  we;
        logic [N-1:0]  last;
        logic          af;
        logic [N-1:0]  grant;
        logic [N-1:0]  ready;
        logic          we_o;
        logic [AW-1:0] waddr;
    } vec_t;

    vec_t tbl[16];
    logic [N-1:0] hs;
    int stall_cnt, lead;
    logic [N-1:0] exp_order[6];

    initial begin
        base[0] = 9'h050; base[1] = 9'h010; base[2] = 9'h090;
        //          we      last    af    grant   ready   we_o  waddr
        tbl[0]  = '{3'b010, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 9'h000};
        tbl[1]  = '{3'b010, 3'b000, 1'b0, 3'b010, 3'b010, 1'b0, 9'h000};
        tbl[2]  = '{3'b010, 3'b000, 1'b0, 3'b010, 3'b010, 1'b1, 9'h010};
        tbl[3]  = '{3'b010, 3'b000, 1'b0, 3'b010, 3'b010, 1'b1, 9'h011};
        tbl[4]  = '{3'b010, 3'b010, 1'b0, 3'b010, 3'b010, 1'b1, 9'h012};
        tbl[5]  = '{3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1, 9'h013};
        tbl[6]  = '{3'b111, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 9'h013};
        tbl[7]  = '{3'b111, 3'b100, 1'b0, 3'b100, 3'b100, 1'b0, 9'h013};
        tbl[8]  = '{3'b111, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1, 9'h090};
        tbl[9]  = '{3'b111, 3'b001, 1'b0, 3'b001, 3'b001, 1'b0, 9'h090};
        tbl[10] = '{3'b111, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 9'h050};
        tbl[11] = '{3'b111, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 9'h050};
        tbl[12] = '{3'b111, 3'b000, 1'b1, 3'b010, 3'b000, 1'b0, 9'h050};
        tbl[13] = '{3'b111, 3'b010, 1'b0, 3'b010, 3'b010, 1'b0, 9'h050};
        tbl[14] = '{3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1, 9'h014};
        tbl[15] = '{3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 9'h014};

        apply_reset();

        // Directed table: single-producer burst, round-robin wrap, almostfull in IDLE and BURST.
        for (int r = 0; r < 16; r++) begin
            bus.req_we = tbl[r].we;
            bus.req_last = tbl[r].last;
            bus.region_almostfull = tbl[r].af;
            for (int i = 0; i < int'(N); i++) begin
                bus.req_waddr[i]     = base[i] + AW'(p_n[i]);
                bus.req_wdata[i]     = beat_data(i, p_n[i]);
                bus.req_wfifobram[i] = 2'(i);
            end
            #1;
            check($sformatf("tbl%0d_grant", r), bus.grant, tbl[r].grant);
            check($sformatf("tbl%0d_ready", r), bus.req_ready, tbl[r].ready);
            check($sformatf("tbl%0d_we", r), bus.we, tbl[r].we_o);
            check($sformatf("tbl%0d_waddr", r), bus.waddr, tbl[r].waddr);
            hs = bus.req_we & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < int'(N); i++) if (hs[i]) p_n[i]++;
        end
`ifdef REGION_ARB_STATS_EN
        check("tbl_stat_beats0", bus.stat_beats[0], 1);
        check("tbl_stat_beats1", bus.stat_beats[1], 5);
        check("tbl_stat_beats2", bus.stat_beats[2], 1);
        check("tbl_stat_stalls", bus.stat_stalls, 1);
`else
        check("tbl_stat_beats1_off", bus.stat_beats[1], 0);
        check("tbl_stat_stalls_off", bus.stat_stalls, 0);
`endif

        // All three producers, continuous 2-beat bursts.
        apply_reset();
        for (int i = 0; i < int'(N); i++) begin p_left[i] = 6; p_blen[i] = 2; end
        run_until_done(200);
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        for (int k = 0; k < 6; k++)
            check($sformatf("rr_order%0d", k), (q_grant.size() > k) ? q_grant[k] : '0, exp_order[k]);

        // MAX_BURST cut: producer 0 streams 40 beats, producer 2 arrives at cycle 5.
        apply_reset();
        p_left[0] = 40;
        p_left[2] = 2; p_blen[2] = 2; p_start[2] = 5;
        run_until_done(300);
        lead = 0;
        while (lead < q_wr.size() && q_wr[lead] < 9'h090) lead++;
        check("max_burst_len", lead, MB);
        check("after_max_burst", (q_wr.size() > lead) ? q_wr[lead] : '0, 9'h090);

        // Almostfull for 5 cycles in the middle of an 8-beat burst.
        apply_reset();
        p_left[0] = 8; p_blen[0] = 8; af_mode = 1;
        stall_cnt = 0;
        while (p_left[0] > 0 && cyc < 100) begin
            if (cyc >= 1 && cyc < 20 && m_owner == 0 && ((cyc >= 4) && (cyc < 9))) stall_cnt++;
            step();
        end
        run_until_done(50);
        check("af_window_stalls_seen", stall_cnt, 5);
`ifdef REGION_ARB_STATS_EN
        check("af_stat_stalls", bus.stat_stalls, 5);
`else
        check("af_stat_stalls_off", bus.stat_stalls, 0);
`endif

        // Reset in the middle of a burst, right after beat 2 was registered.
        apply_reset();
        p_left[0] = 6; p_blen[0] = 6;
        while (p_n[0] < 2 && cyc < 50) step();
        check("pre_reset_we", bus.we, 1);
        reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        apply_reset();
        p_left[2] = 1;
        run_until_done(50);
        check("post_reset_lone_p2", (q_grant.size() > 0) ? q_grant[0] : '0, 3'b100);
        q_grant.delete();
        p_left[0] = 2; p_blen[0] = 2; p_left[2] = 2; p_blen[2] = 2;
        run_until_done(50);
        check("post_reset_p0_first", (q_grant.size() > 0) ? q_grant[0] : '0, 3'b001);
        check("post_reset_p2_second", (q_grant.size() > 1) ? q_grant[1] : '0, 3'b100);

        // Randomized producers with pauses and random almostfull.
        apply_reset();
        af_mode = 2;
        for (int i = 0; i < int'(N); i++) begin
            p_left[i]  = 25;
            p_blen[i]  = $urandom_range(0, 5);
            p_pause[i] = 20;
            p_start[i] = $urandom_range(0, 10);
        end
        run_until_done(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
